// File: rtl/sockit_fifo.sv
// sockit_fifo: single-clock FIFO with req/grt handshake on both ports.
// Depth may be any integer >= 2. The block provides a fill-level output and a
// synchronous clear. With BYP=1, a word can pass from the input port to the
// output port in the same cycle while the FIFO is empty.
module sockit_fifo #(
   parameter int DW  = 8,
   parameter int DD  = 4,
   parameter int CW  = $clog2(DD+1),
   parameter int BYP = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [DW-1:0] bfi_dat,
   input  logic          bfi_req,
   output logic          bfi_grt,
   output logic [DW-1:0] bfo_dat,
   output logic          bfo_req,
   input  logic          bfo_grt,
   output logic [CW-1:0] cnt
);

   localparam int            AW       = $clog2(DD);
   localparam logic [AW-1:0] PTR_LAST = AW'(DD-1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DD);
   localparam logic          BYP_EN   = (BYP != 0);

   logic [DW-1:0] mem_q [DD];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic byp_act;
   logic bfi_trn, bfo_trn;
   logic wr_en, rd_en;

   // Pointers wrap at DD-1 rather than at a power of two.
   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + AW'(1);
   endfunction

   // Handshake outputs and the resulting store/read decisions.
   always_comb begin
      // NOTE: every signal gets a value on every path through this block, so no latches are inferred.
      byp_act = BYP_EN & (cnt_q == '0);
      bfi_grt = rst & ~clr & (cnt_q != CNT_FULL);
      if (byp_act) begin
         bfo_req = rst & ~clr & bfi_req;
         bfo_dat = bfi_dat;
      end else begin
         bfo_req = rst & ~clr & (cnt_q != '0);
         bfo_dat = mem_q[rd_ptr_q];
      end
      bfi_trn = bfi_req & bfi_grt;
      bfo_trn = bfo_req & bfo_grt;
      // A word that passes straight through is neither stored nor popped.
      wr_en   = bfi_trn & ~(byp_act & bfo_trn);
      rd_en   = bfo_trn & ~byp_act;
   end

   // Next pointer and fill-level values; clear overrides both transfers.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (wr_en) wr_ptr_d = next_ptr(wr_ptr_q);
         if (rd_en) rd_ptr_d = next_ptr(rd_ptr_q);
         case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Pointer and fill-level registers.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage array write port.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; cnt gates bfo_req, so stale contents are never presented as valid.
      if (wr_en) mem_q[wr_ptr_q] <= bfi_dat;
   end

   assign cnt = cnt_q;

endmodule
